// File: rtl/bcd_lap_stopwatch.sv
// N-digit BCD lap stopwatch: debounced buttons, run/pause/lap/clear FSM, prescaled counter, 7-segment scanner.
// Optional macro BLINK_PAUSE_EN blanks seg/dp during the second half of each blink period while paused.

module bcd_lap_stopwatch_debounce #(
    parameter int DEBOUNCE_CYC = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [DW-1:0] stab_q, stab_d;

    // Accept a new level only after it has differed from the current one for DEBOUNCE_CYC samples
    always_comb begin
        level_d = level_q;
        stab_d  = stab_q;
        if (sync2_q == level_q) begin
            stab_d = '0;
        end else if (stab_q == DW'(DEBOUNCE_CYC - 1)) begin
            level_d = sync2_q;
            stab_d  = '0;
        end else begin
            stab_d = stab_q + DW'(1);
        end
        press_d = level_d & ~level_q;
    end

    // Synchroniser, debounced level and press pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            stab_q  <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            stab_q  <= stab_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

module bcd_lap_stopwatch #(
    parameter int CLK_HZ       = 12000000,
    parameter int TICK_HZ      = 100,
    parameter int NUM_DIGITS   = 6,
    parameter int DEBOUNCE_CYC = 120000,
    parameter int SCAN_CYC     = 12000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ss_btn,
    input  logic                    lap_btn,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    running,
    output logic                    ovf
);
    localparam int PDIV = CLK_HZ / TICK_HZ;
    localparam int PW   = (PDIV > 1) ? $clog2(PDIV) : 1;
    localparam int SW   = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int DIGW = $clog2(NUM_DIGITS);
    localparam int BW   = 4 * NUM_DIGITS;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_LAP     = 3'd2,
        ST_PAUSE_R = 3'd3,
        ST_PAUSE_L = 3'd4
    } state_t;

    function automatic logic [3:0] digit_max(input int idx);
        if (idx < 2) begin
            return 4'd9;
        end else if ((idx % 2) == 0) begin
            return 4'd9;
        end else begin
            return 4'd5;
        end
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [BW-1:0]     cnt_q, cnt_d, lap_q, lap_d, bcd_q, bcd_d, inc_s;
    logic              ovf_q, ovf_d, running_q, running_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [DIGW-1:0]   dig_q, dig_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              ss_press_s, lap_press_s, run_s, tick_s, carry_s, wrap_s;
    logic              lap_cap_s, clear_s;
    logic [3:0]        digit_s;

    bcd_lap_stopwatch_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ss (
        .clk(clk), .rst_n(rst_n), .btn_raw(ss_btn), .press(ss_press_s)
    );
    bcd_lap_stopwatch_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lap (
        .clk(clk), .rst_n(rst_n), .btn_raw(lap_btn), .press(lap_press_s)
    );

    // Next state per press pulse; start/stop takes priority over lap
    always_comb begin
        state_d   = state_q;
        lap_cap_s = 1'b0;
        clear_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_press_s) state_d = ST_RUN;
                else            state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (ss_press_s) begin
                    state_d = ST_PAUSE_R;
                end else if (lap_press_s) begin
                    state_d   = ST_LAP;
                    lap_cap_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LAP: begin
                if (ss_press_s)       state_d = ST_PAUSE_L;
                else if (lap_press_s) state_d = ST_RUN;
                else                  state_d = ST_LAP;
            end
            ST_PAUSE_R, ST_PAUSE_L: begin
                if (ss_press_s) begin
                    state_d = (state_q == ST_PAUSE_R) ? ST_RUN : ST_LAP;
                end else if (lap_press_s) begin
                    state_d = ST_IDLE;
                    clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ripple BCD increment with mixed 10/6 moduli; a carry out of the top digit is a wrap
    always_comb begin
        run_s   = (state_q == ST_RUN) || (state_q == ST_LAP);
        tick_s  = run_s && (presc_q == PW'(PDIV - 1));
        carry_s = tick_s;
        inc_s   = cnt_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry_s) begin
                if (cnt_q[4*i +: 4] == digit_max(i)) begin
                    inc_s[4*i +: 4] = 4'd0;
                end else begin
                    inc_s[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry_s         = 1'b0;
                end
            end else begin
                inc_s[4*i +: 4] = cnt_q[4*i +: 4];
            end
        end
        wrap_s = carry_s;
    end

    // Prescaler, count, lap snapshot, overflow and displayed value
    always_comb begin
        if (state_d == ST_IDLE)  presc_d = '0;
        else if (tick_s)         presc_d = '0;
        else if (run_s)          presc_d = presc_q + PW'(1);
        else                     presc_d = presc_q;

        if (clear_s)             cnt_d = '0;
        else if (tick_s)         cnt_d = inc_s;
        else                     cnt_d = cnt_q;

        if (clear_s)             lap_d = '0;
        else if (lap_cap_s)      lap_d = cnt_q;
        else                     lap_d = lap_q;

        if (clear_s)             ovf_d = 1'b0;
        else if (wrap_s)         ovf_d = 1'b1;
        else                     ovf_d = ovf_q;

        if ((state_q == ST_LAP) || (state_q == ST_PAUSE_L)) bcd_d = lap_q;
        else                                                 bcd_d = cnt_q;

        running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    end

`ifdef BLINK_PAUSE_EN
    localparam int BLINK_TICKS = (TICK_HZ / 2 > 1) ? TICK_HZ / 2 : 2;
    localparam int BLW         = $clog2(BLINK_TICKS);

    logic [PW-1:0]  blk_presc_q, blk_presc_d;
    logic [BLW-1:0] blk_cnt_q, blk_cnt_d;
    logic           paused_s, blk_tick_s, blank_s;

    // Private tick generator for blinking; the main prescaler stays frozen while paused
    always_comb begin
        paused_s   = (state_q == ST_PAUSE_R) || (state_q == ST_PAUSE_L);
        blk_tick_s = paused_s && (blk_presc_q == PW'(PDIV - 1));
        if (!paused_s)       blk_presc_d = '0;
        else if (blk_tick_s) blk_presc_d = '0;
        else                 blk_presc_d = blk_presc_q + PW'(1);
        if (!paused_s)                                    blk_cnt_d = '0;
        else if (blk_tick_s && (blk_cnt_q == BLW'(BLINK_TICKS - 1))) blk_cnt_d = '0;
        else if (blk_tick_s)                              blk_cnt_d = blk_cnt_q + BLW'(1);
        else                                              blk_cnt_d = blk_cnt_q;
        blank_s = paused_s && (blk_cnt_q >= BLW'(BLINK_TICKS / 2));
    end

    // Blink counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_presc_q <= '0;
            blk_cnt_q   <= '0;
        end else begin
            blk_presc_q <= blk_presc_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end
`endif

    // Digit scan; seg/dp are computed for the next enabled digit so they change together with an
    always_comb begin
        if (scan_q == SW'(SCAN_CYC - 1)) begin
            scan_d = '0;
            if (dig_q == DIGW'(NUM_DIGITS - 1)) dig_d = '0;
            else                                 dig_d = dig_q + DIGW'(1);
        end else begin
            scan_d = scan_q + SW'(1);
            dig_d  = dig_q;
        end
        an_d    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig_d;
        digit_s = bcd_q[4*int'(dig_d) +: 4];
`ifdef BLINK_PAUSE_EN
        seg_d = blank_s ? 7'h00 : seg_decode(digit_s);
        dp_d  = blank_s ? 1'b0 : ((dig_d[0] == 1'b0) && (dig_d != {DIGW{1'b0}}));
`else
        seg_d = seg_decode(digit_s);
        dp_d  = (dig_d[0] == 1'b0) && (dig_d != {DIGW{1'b0}});
`endif
    end

    // All state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            lap_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            running_q <= 1'b0;
            scan_q    <= '0;
            dig_q     <= '0;
            an_q      <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
            seg_q     <= 7'h3F;
            dp_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            lap_q     <= lap_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            running_q <= running_d;
            scan_q    <= scan_d;
            dig_q     <= dig_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;
    assign bcd     = bcd_q;
    assign running = running_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_bcd_lap_stopwatch.sv
// Directed bench for bcd_lap_stopwatch: a 6-digit instance at 10 cycles/tick and a
// 4-digit instance at 1 cycle/tick used to reach the wrap point quickly.
module tb_bcd_lap_stopwatch;
    logic        clk;
    logic        rst_n;
    logic        ss_btn, lap_btn, ss2_btn, lap2_btn;
    logic [6:0]  seg, seg2;
    logic        dp, dp2;
    logic [5:0]  an;
    logic [3:0]  an2;
    logic [23:0] bcd;
    logic [15:0] bcd2;
    logic        running, running2, ovf, ovf2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bcd_lap_stopwatch #(
        .CLK_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(6), .DEBOUNCE_CYC(4), .SCAN_CYC(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ss_btn(ss_btn), .lap_btn(lap_btn),
        .seg(seg), .dp(dp), .an(an), .bcd(bcd), .running(running), .ovf(ovf)
    );

    bcd_lap_stopwatch #(
        .CLK_HZ(100), .TICK_HZ(100), .NUM_DIGITS(4), .DEBOUNCE_CYC(4), .SCAN_CYC(2)
    ) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .ss_btn(ss2_btn), .lap_btn(lap2_btn),
        .seg(seg2), .dp(dp2), .an(an2), .bcd(bcd2), .running(running2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Advance n clock edges; all driving and sampling happens 1ns after a rising edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic goto(input int t);
        if (t > cyc) step(t - cyc);
    endtask

    int t0, w, s, f, r, r2;
    logic [5:0] exp_an;
    logic       exp_dp;

    initial begin
        rst_n = 1'b0; ss_btn = 1'b0; lap_btn = 1'b0; ss2_btn = 1'b0; lap2_btn = 1'b0;
        step(3);
        check_val("rst_bcd", 32'(bcd), 32'h0);
        check_val("rst_an", 32'(an), 32'h1);
        check_val("rst_seg", 32'(seg), 32'h3F);
        check_val("rst_dp", 32'(dp), 32'h0);
        check_val("rst_running", 32'(running), 32'h0);
        check_val("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;

        // scan order and decimal points
        for (int i = 0; i < 8; i++) if (an != 6'b000010) step(1);
        check_val("scan_an1", 32'(an), 32'h02);
        check_val("scan_dp1", 32'(dp), 32'h0);
        for (int k = 2; k < 6; k++) begin
            step(2);
            exp_an = 6'b000001 << k;
            exp_dp = (k == 2) || (k == 4);
            check_val("scan_an", 32'(an), 32'(exp_an));
            check_val("scan_dp", 32'(dp), 32'(exp_dp));
            check_val("scan_seg", 32'(seg), 32'h3F);
        end
        step(1);
        check_val("scan_hold", 32'(an), 32'h20);
        step(1);
        check_val("scan_wrap_an", 32'(an), 32'h01);
        check_val("scan_wrap_dp", 32'(dp), 32'h0);

        // rollover on the fast 4-digit instance: 59:99 -> 00:00 with ovf
        t0 = cyc + 2;
        goto(t0);      ss2_btn = 1'b1;
        goto(t0 + 6);  check_val("roll_press_early", 32'(running2), 32'h0);
        goto(t0 + 7);  check_val("roll_press_run", 32'(running2), 32'h1);
        goto(t0 + 10); ss2_btn = 1'b0;
        w = t0 + 7;
        goto(w + 5999);
        check_val("roll_pre_bcd", 32'(bcd2), 32'h5998);
        check_val("roll_pre_ovf", 32'(ovf2), 32'h0);
        goto(w + 6000);
        check_val("roll_max_bcd", 32'(bcd2), 32'h5999);
        check_val("roll_ovf_set", 32'(ovf2), 32'h1);
        goto(w + 6001);
        check_val("roll_zero_bcd", 32'(bcd2), 32'h0000);
        check_val("roll_still_run", 32'(running2), 32'h1);
        goto(w + 6005);
        check_val("roll_continue", 32'(bcd2), 32'h0004);
        s = w + 6010;
        goto(s);       ss2_btn = 1'b1;
        goto(s + 10);  ss2_btn = 1'b0;
        goto(s + 20);  lap2_btn = 1'b1;
        goto(s + 26);  check_val("roll_ovf_sticky", 32'(ovf2), 32'h1);
        goto(s + 27);  check_val("roll_ovf_clear", 32'(ovf2), 32'h0);
        goto(s + 30);  lap2_btn = 1'b0;
        check_val("roll_idle", 32'(running2), 32'h0);
        check_val("roll_bcd_clear", 32'(bcd2), 32'h0);

        // bouncing start button: one press only
        t0 = cyc + 2;
        for (int k = 0; k < 5; k++) begin
            goto(t0 + 4*k);     ss_btn = 1'b1;
            goto(t0 + 4*k + 2); ss_btn = 1'b0;
        end
        f = t0 + 20;
        goto(f - 1);  check_val("bounce_idle", 32'(running), 32'h0);
        ss_btn = 1'b0;
        goto(f);      ss_btn = 1'b1;
        goto(f + 6);  check_val("bounce_latency", 32'(running), 32'h0);
        goto(f + 7);  check_val("bounce_run", 32'(running), 32'h1);
        r = f + 7;
        goto(r + 3);  ss_btn = 1'b0;
        goto(r + 255);
        check_val("run_250", 32'(bcd), 32'h000025);

        // lap freeze at 00:01:50
        goto(r + 1498); lap_btn = 1'b1;
        goto(r + 1506); check_val("lap_freeze0", 32'(bcd), 32'h000150);
        goto(r + 1508); lap_btn = 1'b0;
        goto(r + 1800);
        check_val("lap_freeze_mid", 32'(bcd), 32'h000150);
        check_val("lap_running", 32'(running), 32'h1);
        goto(r + 1996); lap_btn = 1'b1;
        goto(r + 2003); check_val("lap_freeze_end", 32'(bcd), 32'h000150);
        goto(r + 2004); check_val("lap_return", 32'(bcd), 32'h000200);
        goto(r + 2006); lap_btn = 1'b0;

        // clear back to idle
        goto(r + 2020); ss_btn = 1'b1;
        goto(r + 2030); ss_btn = 1'b0;
        goto(r + 2040); lap_btn = 1'b1;
        goto(r + 2050); lap_btn = 1'b0;
        check_val("clear_bcd", 32'(bcd), 32'h0);
        check_val("clear_running", 32'(running), 32'h0);
        goto(r + 2060); ss_btn = 1'b1;
        r2 = r + 2067;
        goto(r + 2070); ss_btn = 1'b0;

        // pause at 00:00:07 with prescaler at 3, resume 100 cycles later
        goto(r2 + 66);  ss_btn = 1'b1;
        goto(r2 + 74);
        check_val("pause_bcd", 32'(bcd), 32'h000007);
        check_val("pause_running", 32'(running), 32'h0);
        goto(r2 + 76);  ss_btn = 1'b0;
        goto(r2 + 150); check_val("pause_hold", 32'(bcd), 32'h000007);
        goto(r2 + 166); ss_btn = 1'b1;
        goto(r2 + 176); ss_btn = 1'b0;
        goto(r2 + 180); check_val("resume_edge", 32'(bcd), 32'h000007);
        goto(r2 + 181); check_val("resume_first", 32'(bcd), 32'h000008);

        // simultaneous ss and lap during RUN: pause wins
        goto(r2 + 196); ss_btn = 1'b1; lap_btn = 1'b1;
        goto(r2 + 206); ss_btn = 1'b0; lap_btn = 1'b0;
        goto(r2 + 210);
        check_val("both_running", 32'(running), 32'h0);
        check_val("both_bcd", 32'(bcd), 32'h000010);
        goto(r2 + 220); ss_btn = 1'b1;
        goto(r2 + 230); ss_btn = 1'b0;
        goto(r2 + 236);
        check_val("both_resume_bcd", 32'(bcd), 32'h000011);
        check_val("both_resume_run", 32'(running), 32'h1);

        // asynchronous reset mid-cycle while running at 00:12:34
        goto(r2 + 12466);
        check_val("pre_reset_bcd", 32'(bcd), 32'h001234);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_bcd", 32'(bcd), 32'h0);
        check_val("async_rst_running", 32'(running), 32'h0);
        check_val("async_rst_an", 32'(an), 32'h01);
        check_val("async_rst_seg", 32'(seg), 32'h3F);
        check_val("async_rst_dp", 32'(dp), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_lap_stopwatch.md
Name: bcd_lap_stopwatch

Overview:
Parametrised successor to the TT stopwatch top. It provides an N-digit BCD time counter (hundredths, seconds, minutes, and further 10/6 digit pairs) with an on-chip prescaler, debounced buttons, a run/pause/lap/clear FSM and an N-digit multiplexed 7-segment scanner. It sits directly under the tt_um_* wrapper, which maps buttons from ui_in and drives uo_out and uio_out.

Parameters:
CLK_HZ, 12000000, input clock frequency.
TICK_HZ, 100, count rate; the LSB digit weight is 1/TICK_HZ s.
NUM_DIGITS, 6, number of BCD digits, even, range 2..8.
DEBOUNCE_CYC, 120000, cycles an input must be stable before it is accepted.
SCAN_CYC, 12000, cycles each digit is enabled during display scan.

Ports:
clk  in  1  global clock
rst_n  in  1  asynchronous active-low reset
ss_btn  in  1  raw start/stop button, active-high
lap_btn  in  1  raw lap/clear button, active-high
seg  out  7  segments a..g (bit0=a), active-high
dp  out  1  decimal point for the currently enabled digit
an  out  NUM_DIGITS  one-hot digit enable, active-high, bit0 = LSB digit
bcd  out  4*NUM_DIGITS  value currently displayed (live count or lap snapshot)
running  out  1  high in RUN or LAP
ovf  out  1  sticky wrap flag

Behaviour:
- Reset (async, rst_n=0): state IDLE; count, lap register, prescaler, debouncers and scan counter all 0. Outputs: bcd=0, an=1 (digit0), seg=7'h3F, dp=0, running=0, ovf=0.
- Input conditioning: 2-flop synchroniser, then a stable counter. The debounced level updates after DEBOUNCE_CYC consecutive equal samples. A 1-cycle press pulse fires on each debounced 0->1 edge. Release produces no pulse.
- Digit moduli: digits 0,1 are mod 10 (hundredths). Above them, pairs run mod 10 (even index) then mod 6 (odd index). Digit i increments when all lower digits are at their maximum on a tick.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 and emits a 1-cycle tick at the terminal count. It advances only in RUN or LAP, holds in PAUSE, and clears on entry to IDLE.
- Count update: on a tick, the count increments if the registered state is RUN or LAP, evaluated before any command applied in the same cycle.
- Wrap: the all-max count plus a tick becomes all-zero, sets ovf=1, and counting continues. ovf clears only on clear (to IDLE) or reset.
- FSM, per press pulse:
  - IDLE: ss -> RUN; lap ignored.
  - RUN: ss -> PAUSE; lap -> LAP, copying the count into the lap register that cycle.
  - LAP: ss -> PAUSE (display stays frozen on the lap register); lap -> RUN (display returns to live).
  - PAUSE: ss -> RUN if entered from RUN, or -> LAP if entered from LAP; lap -> IDLE (clear count, lap register and ovf).
  - Both pulses in the same cycle: ss wins; lap is dropped.
- Display source: lap register in LAP and in a PAUSE entered from LAP; live count otherwise. bcd is registered with 1-cycle latency from a count/lap update.
- Scan: an rotates digit0 -> digit1 -> ... -> digit(N-1) -> digit0, changing every SCAN_CYC cycles.
  - seg is the registered decode of the enabled digit and is aligned with an.
  - Values 10..15 cannot occur and decode to blank.
  - dp=1 when the enabled digit index is even and nonzero (separators at 2, 4, ...).
- Latency, raw press to state change: 2 (sync) + DEBOUNCE_CYC + 1 cycles.

Optional Feature:
Macro BLINK_PAUSE_EN.
- Defined: in PAUSE, seg and dp are forced to 0 during the second half of each blink period. The blink period is TICK_HZ/2 ticks, counted with the prescaler tick free-running in PAUSE for blink purposes only; the count itself still holds. an continues to scan.
- Undefined: no blink logic; the display is steady in every state.

Test Plan:
Use CLK_HZ=1000, TICK_HZ=100, DEBOUNCE_CYC=4, SCAN_CYC=2, NUM_DIGITS=6 (10 cycles per tick).
- Reset mid-run: assert rst_n=0 asynchronously mid-cycle while RUN at count 00:12:34 -> bcd=0, running=0, an=6'b000001, seg=7'h3F in the same cycle.
- Bounce: toggle ss_btn 1/0 every 2 cycles for 20 cycles, then hold 1 -> exactly one press, entering RUN 7 cycles after the final rise. After 250 cycles, bcd=24'h000025.
- Rollover: preload near max by running to 59:59:99 -> next tick gives bcd=0 and ovf=1, running stays 1. Clear via ss then lap -> ovf=0, state IDLE.
- Lap freeze: lap press at live 00:01:50 -> bcd holds 24'h000150 for 500 cycles while the internal count advances. Second lap press -> bcd jumps to 24'h000200.
- Pause/resume: pause at 00:00:07 (prescaler at 3), resume after 100 cycles -> first increment arrives 7 cycles after resume, giving 00:00:08.
- Simultaneous press: ss and lap pulses in the same cycle during RUN -> PAUSE entered and lap register unchanged. Scan check: an cycles 1,2,4,...,32 every 2 cycles, with dp=1 only at an=6'b000100 and 6'b010000.
